// File: rtl/piso_tx_ctrl_if.sv
// piso_tx_ctrl_if: upstream valid/ready word port plus the PISO drive and frame qualifiers
interface piso_tx_ctrl_if #(parameter int WIDTH = 8);
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             piso_load;
   logic [WIDTH-1:0] piso_data;
   logic             ser_valid;
   logic             ser_first;
   logic             ser_last;
   logic             busy;
   logic             frame_done;
   modport master (
      output flush, in_valid, in_data,
      input  in_ready, piso_load, piso_data, ser_valid, ser_first, ser_last, busy, frame_done
   );
   modport slave (
      input  flush, in_valid, in_data,
      output in_ready, piso_load, piso_data, ser_valid, ser_first, ser_last, busy, frame_done
   );
endinterface

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: buffers words and sequences load/shift/gap frames for an external PISO register
module piso_tx_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int GAP   = 1
) (
   input logic           clk,
   input logic           reset,
   piso_tx_ctrl_if.slave bus
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PAUSE} state_t;
   state_t           state, nxt;
   logic [WIDTH-1:0] mem [2**AW];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic [BW-1:0]    bit_cnt;
   logic [3:0]       gap_cnt;
   logic [WIDTH-1:0] data_q;
   logic             done_q;
   logic             push, pop, empty, full, frame_end, gap_end;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign empty          = count == '0;
   assign full           = count == CW'(DEPTH);
   assign bus.in_ready   = !full && !bus.flush;
   assign push           = bus.in_valid && bus.in_ready;
   assign pop            = state == LOAD;
   assign frame_end      = bit_cnt == BW'(WIDTH - 1);
   assign gap_end        = gap_cnt == 4'(GAP - 1);
   assign bus.piso_load  = state == LOAD;
   assign bus.piso_data  = data_q;
   assign bus.ser_valid  = state == SHIFT;
   assign bus.ser_first  = state == SHIFT && bit_cnt == '0;
   assign bus.ser_last   = state == SHIFT && frame_end;
   assign bus.busy       = state != IDLE || !empty;
   assign bus.frame_done = done_q;

   // word storage; contents need no reset since only occupied slots are read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end

   // FIFO pointers and occupancy: push on handshake, pop as LOAD completes, flush empties
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
         rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
         count  <= count + CW'(push) - CW'(pop);
      end
   end

   // next frame step; flush overrides every transition
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = empty ? IDLE : LOAD;
         LOAD:    nxt = SHIFT;
         SHIFT:   nxt = !frame_end ? SHIFT : GAP > 0 ? PAUSE : empty ? IDLE : LOAD;
         PAUSE:   nxt = !gap_end ? PAUSE : empty ? IDLE : LOAD;
         default: nxt = IDLE;
      endcase
      if (bus.flush) nxt = IDLE;
   end

   // sequencer state, bit/gap counters, presented word and completion pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         gap_cnt <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state   <= nxt;
         bit_cnt <= state == SHIFT && nxt == SHIFT ? bit_cnt + 1'b1 : '0;
         gap_cnt <= state == PAUSE && nxt == PAUSE ? gap_cnt + 1'b1 : '0;
         data_q  <= nxt == LOAD ? mem[rd_ptr] : data_q;
         done_q  <= state == SHIFT && frame_end && !bus.flush;
      end
   end
endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: vector table, directed corner sequences and a frame-timeline model for GAP=1 and GAP=0 instances
module tb_piso_tx_ctrl;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
   typedef struct {logic v; logic [7:0] d; logic [15:0] e;} vec_t;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       iv    = 1'b0;
   logic       fl    = 1'b0;
   logic [7:0] id    = '0;
   logic [7:0] sr0, sr1;
   logic [15:0] ob [2];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         mt [2];
   logic       md [2];
   logic [7:0] mc [2];
   logic [7:0] mq [2][$];
   vec_t       tbl [14];
   logic [7:0] w [3];
   logic [7:0] ld_d [3];
   logic [7:0] bits;
   logic [15:0] msk;
   int         acc_c [3];
   int         ld_c [3];
   int         na, nl, r, found, nb, fpos, lpos, prevl, lastc, bad_v;
   logic       acc_now;

   piso_tx_ctrl_if #(.WIDTH(WIDTH)) if0 ();
   piso_tx_ctrl_if #(.WIDTH(WIDTH)) if1 ();
   piso_tx_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(1)) u0 (.clk(clk), .reset(rst_n), .bus(if0));
   piso_tx_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(0)) u1 (.clk(clk), .reset(rst_n), .bus(if1));

   always #5 clk = ~clk;
   assign if0.flush    = fl;
   assign if0.in_valid = iv;
   assign if0.in_data  = id;
   assign if1.flush    = fl;
   assign if1.in_valid = iv;
   assign if1.in_data  = id;
   assign ob[0] = {if0.in_ready, if0.piso_load, if0.ser_valid, if0.ser_first, if0.ser_last,
                   if0.busy, if0.frame_done, sr0[7], if0.piso_data};
   assign ob[1] = {if1.in_ready, if1.piso_load, if1.ser_valid, if1.ser_first, if1.ser_last,
                   if1.busy, if1.frame_done, sr1[7], if1.piso_data};

   // external shift registers: capture on load, otherwise shift MSB first
   always @(posedge clk) begin
      sr0 <= if0.piso_load ? if0.piso_data : sr0 << 1;
      sr1 <= if1.piso_load ? if1.piso_data : sr1 << 1;
   end

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      fl = 1'b1;
      iv = 1'b0;
      step();
      fl = 1'b0;
      step();
   endtask

   // reference: t is the cycle offset inside the current frame (-1 when idle);
   // offset 0 loads, 1..WIDTH carry bits, the rest are gap cycles
   task automatic mstep(int i);
      int p, t, nt;
      logic rdy, v, sb;
      logic [15:0] e, m;
      t   = mt[i];
      p   = WIDTH + 1 + (i == 0 ? 1 : 0);
      rdy = mq[i].size() < DEPTH && !fl;
      v   = t >= 1 && t <= WIDTH;
      sb  = 1'b0;
      if (v) sb = mc[i][WIDTH - t];
      e = {rdy, t == 0, v, t == 1, t == WIDTH, t >= 0 || mq[i].size() > 0, md[i], sb, mc[i]};
      m = v ? 16'hFFFF : 16'hFEFF;
      chk($sformatf("u%0d outputs t=%0d", i, t), int'(ob[i] & m), int'(e & m));
      if (fl) begin
         mq[i].delete();
         mt[i] = -1;
         md[i] = 1'b0;
      end else begin
         nt    = (t < 0 || t == p - 1) ? (mq[i].size() == 0 ? -1 : 0) : t + 1;
         md[i] = t == WIDTH;
         if (t == 0) void'(mq[i].pop_front());
         if (iv && rdy) mq[i].push_back(id);
         if (nt == 0) mc[i] = mq[i][0];
         mt[i] = nt;
      end
   endtask

   // compare both instances against the model every cycle, away from the active edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            mq[i].delete();
            mt[i] = -1;
            md[i] = 1'b0;
            mc[i] = '0;
            chk($sformatf("u%0d reset outputs", i), int'(ob[i] & 16'hFEFF), int'({!fl, 15'h0}));
         end else mstep(i);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      tbl = '{
         '{1'b1, 8'hA5, 16'h8000}, '{1'b0, 8'h00, 16'h8400}, '{1'b0, 8'h00, 16'hC4A5},
         '{1'b0, 8'h00, 16'hB5A5}, '{1'b0, 8'h00, 16'hA4A5}, '{1'b0, 8'h00, 16'hA5A5},
         '{1'b0, 8'h00, 16'hA4A5}, '{1'b0, 8'h00, 16'hA4A5}, '{1'b0, 8'h00, 16'hA5A5},
         '{1'b0, 8'h00, 16'hA4A5}, '{1'b0, 8'h00, 16'hADA5}, '{1'b0, 8'h00, 16'h86A5},
         '{1'b0, 8'h00, 16'h80A5}, '{1'b0, 8'h00, 16'h80A5}
      };
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         iv = tbl[k].v;
         id = tbl[k].d;
         @(negedge clk);
         msk = tbl[k].e[13] ? 16'hFFFF : 16'hFEFF;
         chk($sformatf("vec%0d", k), int'(ob[0] & msk), int'(tbl[k].e & msk));
         step();
      end
      w  = '{8'h3C, 8'hFF, 8'h01};
      na = 0;
      nl = 0;
      iv = 1'b1;
      id = w[0];
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (if0.piso_load && nl < 3) begin
            ld_c[nl] = c;
            ld_d[nl] = if0.piso_data;
            nl++;
         end
         acc_now = iv && if0.in_ready;
         if (acc_now) acc_c[na] = c;
         step();
         if (acc_now) begin
            na++;
            if (na < 3) id = w[na];
            else iv = 1'b0;
         end
      end
      chk("b2b accepts", na, 3);
      chk("b2b loads", nl, 3);
      if (na == 3 && nl == 3) begin
         chk("b2b second accept", acc_c[1] - acc_c[0], 1);
         chk("b2b ready gap", acc_c[2] - acc_c[1], 2);
         chk("b2b third after load", acc_c[2] - ld_c[0], 1);
         chk("b2b period 1", ld_c[1] - ld_c[0], 10);
         chk("b2b period 2", ld_c[2] - ld_c[1], 10);
         for (int k = 0; k < 3; k++) chk($sformatf("b2b word%0d", k), int'(ld_d[k]), int'(w[k]));
      end
      clear();
      iv    = 1'b1;
      nl    = 0;
      lastc = -100;
      prevl = -100;
      bad_v = 0;
      for (int c = 0; c < 45; c++) begin
         id = 8'(c * 7 + 3);
         @(negedge clk);
         if (if1.ser_last) lastc = c;
         if (if1.piso_load) begin
            if (nl > 0) begin
               chk("g0 period", c - prevl, 9);
               chk("g0 load after last", c - lastc, 1);
            end
            prevl = c;
            nl++;
         end
         if (nl > 0 && !(if1.ser_valid ^ if1.piso_load)) bad_v++;
         step();
      end
      iv = 1'b0;
      chk("g0 loads", nl, 5);
      chk("g0 valid low only in load", bad_v, 0);
      clear();
      iv = 1'b1;
      id = 8'h5A;
      step();
      id = 8'h77;
      step();
      iv    = 1'b0;
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(negedge clk);
         found = int'(if0.ser_first);
         if (found == 0) step();
      end
      chk("flush reach first bit", found, 1);
      step();
      step();
      step();
      fl = 1'b1;
      iv = 1'b1;
      id = 8'hEE;
      @(negedge clk);
      chk("flush in_ready", int'(if0.in_ready), 0);
      chk("flush on bit4", int'(if0.ser_valid), 1);
      step();
      fl = 1'b0;
      iv = 1'b0;
      @(negedge clk);
      chk("flush ser_valid", int'(if0.ser_valid), 0);
      chk("flush busy", int'(if0.busy), 0);
      chk("flush frame_done", int'(if0.frame_done), 0);
      nl    = 0;
      bad_v = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         @(negedge clk);
         nl    += int'(if0.piso_load);
         bad_v += int'(if0.busy | if0.frame_done);
      end
      chk("flush no reload", nl, 0);
      chk("flush stays idle", bad_v, 0);
      step();
      iv = 1'b1;
      id = 8'h3C;
      step();
      iv    = 1'b0;
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(negedge clk);
         found = int'(if0.ser_first);
         if (found == 0) step();
      end
      chk("reset reach first bit", found, 1);
      step();
      step();
      #2 rst_n = 1'b0;
      #1 chk("async reset outputs", int'(ob[0] & 16'hFEFF), int'(16'h8000));
      step();
      rst_n = 1'b1;
      iv    = 1'b1;
      id    = 8'h81;
      step();
      iv   = 1'b0;
      bits = '0;
      nb   = 0;
      fpos = 0;
      lpos = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (if0.ser_valid && nb < 8) begin
            bits = {bits[6:0], sr0[7]};
            nb++;
            if (if0.ser_first) fpos = nb;
            if (if0.ser_last) lpos = nb;
         end
         step();
      end
      chk("post-reset bit count", nb, 8);
      chk("post-reset bits", int'(bits), 32'h81);
      chk("post-reset first pos", fpos, 1);
      chk("post-reset last pos", lpos, 8);
      nl    = 0;
      bad_v = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         nl    += int'(if0.piso_load);
         bad_v += int'(if0.busy);
         step();
      end
      chk("idle no load", nl, 0);
      chk("idle not busy", bad_v, 0);
      for (int c = 0; c < 1500; c++) begin
         r     = int'($urandom_range(0, 199));
         fl    = r < 5;
         rst_n = !(r >= 5 && r < 7);
         iv    = $urandom_range(0, 99) < 55;
         id    = 8'($urandom);
         step();
      end
      fl    = 1'b0;
      rst_n = 1'b1;
      iv    = 1'b0;
      step();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
